keycode_commander: RTL and testbench

Reads the 16-bit `keycode` word that the NIOS II USB software publishes and turns key presses into simulation control: run/pause, single-step, speed selection and reseed requests. It sits between `nios_system.keycode_export` and the simulation controllers. `RUN` drives `simState_controller`, and `slowdown_factor` drives the gamestate `clock_cutter`, replacing the constant slowdown factor. `game_tick` is a one-`Clk` pulse per game step, produced from the game clock by the top level.

---
 rtl/keycode_commander.sv | 201 ++++++++++++++++++++
 tb/tb_keycode_commander.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/keycode_commander.sv
// Turns USB HID keycodes from the NIOS software into simulation control:
// run/pause, single-step, reseed requests and a saturating speed level with auto-repeat.
module keycode_commander #(
    parameter int unsigned BASE_FACTOR   = 50000000,
    parameter int unsigned FACTOR_bits   = 26,
    parameter int unsigned DEFAULT_LEVEL = 0,
    parameter int unsigned REPEAT_DELAY  = 25000000,
    parameter int unsigned REPEAT_PERIOD = 5000000
) (
    input  logic                   Clk,
    input  logic                   RESET_SIM,
    input  logic [15:0]            keycode,
    input  logic                   game_tick,
    output logic                   RUN,
    output logic                   step_req,
    output logic                   reseed_req,
    output logic [2:0]             speed_level,
    output logic [FACTOR_bits-1:0] slowdown_factor,
    output logic                   cmd_valid,
    output logic [2:0]             cmd_code
);

    localparam logic [2:0] CmdNone   = 3'd0;
    localparam logic [2:0] CmdToggle = 3'd1;
    localparam logic [2:0] CmdStep   = 3'd2;
    localparam logic [2:0] CmdFaster = 3'd3;
    localparam logic [2:0] CmdSlower = 3'd4;
    localparam logic [2:0] CmdReseed = 3'd5;

    localparam logic [25:0]            DelayCnt     = 26'(REPEAT_DELAY);
    localparam logic [25:0]            PeriodCnt    = 26'(REPEAT_PERIOD);
    localparam logic [FACTOR_bits-1:0] BaseFactor   = FACTOR_bits'(BASE_FACTOR);
    localparam logic [2:0]             DefaultLevel = 3'(DEFAULT_LEVEL);

    typedef enum logic [1:0] {StPaused, StRunning, StStepping} state_e;

    function automatic logic [2:0] map_key(input logic [7:0] key);
        case (key)
            8'h2C:   map_key = CmdToggle;
            8'h16:   map_key = CmdStep;
            8'h2E:   map_key = CmdFaster;
            8'h2D:   map_key = CmdSlower;
            8'h15:   map_key = CmdReseed;
            default: map_key = CmdNone;
        endcase
    endfunction

    state_e                  r_state;
    logic [15:0]             r_kc_q;
    logic [15:0]             r_kc_prev;
    logic [2:0]              r_level;
    logic [FACTOR_bits-1:0]  r_factor;
    logic                    r_step_req;
    logic                    r_reseed_req;
    logic                    r_cmd_valid;
    logic [2:0]              r_cmd_code;
    logic [25:0]             r_hold_cnt;
    logic [7:0]              r_hold_key;
    logic                    r_rep_phase;

    state_e      w_state_nxt;
    logic [2:0]  w_level_nxt;
    logic        w_step_nxt;
    logic        w_reseed_nxt;
    logic        w_valid_nxt;
    logic [2:0]  w_code_nxt;
    logic [25:0] w_hold_cnt_nxt;
    logic [7:0]  w_hold_key_nxt;
    logic        w_rep_phase_nxt;

    logic [7:0]  w_slot_a;
    logic [7:0]  w_slot_b;
    logic        w_a_new;
    logic        w_b_new;
    logic        w_any_new;
    logic [7:0]  w_press_key;
    logic [2:0]  w_press_cmd;
    logic        w_held;
    logic        w_rep_fire;
    logic [2:0]  w_cmd;

    assign w_slot_a = r_kc_q[7:0];
    assign w_slot_b = r_kc_q[15:8];

    // A press is new only if the key was absent from both slots of the prior sample.
    assign w_a_new = (w_slot_a != 8'h00) && (map_key(w_slot_a) != CmdNone)
                     && (w_slot_a != r_kc_prev[7:0]) && (w_slot_a != r_kc_prev[15:8]);
    assign w_b_new = (w_slot_b != 8'h00) && (map_key(w_slot_b) != CmdNone)
                     && (w_slot_b != r_kc_prev[7:0]) && (w_slot_b != r_kc_prev[15:8]);

    assign w_any_new   = w_a_new | w_b_new;
    assign w_press_key = w_a_new ? w_slot_a : (w_b_new ? w_slot_b : 8'h00);
    assign w_press_cmd = map_key(w_press_key);

    assign w_held = (r_hold_key != 8'h00)
                    && ((w_slot_a == r_hold_key) || (w_slot_b == r_hold_key));
    assign w_rep_fire = !w_any_new && w_held
                        && (r_hold_cnt == (r_rep_phase ? PeriodCnt : DelayCnt));

    assign w_cmd = w_any_new ? w_press_cmd : (w_rep_fire ? map_key(r_hold_key) : CmdNone);

    // After the first repeat the counter restarts at 1 and runs to the period.
    always_comb begin
        w_hold_cnt_nxt  = 26'd0;
        w_hold_key_nxt  = 8'h00;
        w_rep_phase_nxt = 1'b0;
        if (w_any_new) begin
            if (w_press_cmd == CmdFaster || w_press_cmd == CmdSlower) begin
                w_hold_key_nxt = w_press_key;
            end
        end else if (w_held) begin
            w_hold_key_nxt = r_hold_key;
            if (w_rep_fire) begin
                w_hold_cnt_nxt  = 26'd1;
                w_rep_phase_nxt = 1'b1;
            end else begin
                w_hold_cnt_nxt  = r_hold_cnt + 26'd1;
                w_rep_phase_nxt = r_rep_phase;
            end
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_level_nxt  = r_level;
        w_step_nxt   = 1'b0;
        w_reseed_nxt = 1'b0;
        w_valid_nxt  = 1'b0;
        if (r_state == StStepping && game_tick) begin
            w_state_nxt = StPaused;
        end
        case (w_cmd)
            CmdToggle: begin
                w_valid_nxt = 1'b1;
                w_state_nxt = (r_state == StRunning) ? StPaused : StRunning;
            end
            CmdStep: begin
                if (r_state == StPaused) begin
                    w_valid_nxt = 1'b1;
                    w_step_nxt  = 1'b1;
                    w_state_nxt = StStepping;
                end
            end
            CmdReseed: begin
                if (r_state == StPaused) begin
                    w_valid_nxt  = 1'b1;
                    w_reseed_nxt = 1'b1;
                end
            end
            CmdFaster: begin
                w_valid_nxt = 1'b1;
                if (r_level != 3'd7) w_level_nxt = r_level + 3'd1;
            end
            CmdSlower: begin
                w_valid_nxt = 1'b1;
                if (r_level != 3'd0) w_level_nxt = r_level - 3'd1;
            end
            default: ;
        endcase
        w_code_nxt = w_valid_nxt ? w_cmd : CmdNone;
    end

    always_ff @(posedge Clk) begin
        if (RESET_SIM) begin
            r_state      <= StPaused;
            r_kc_q       <= 16'h0000;
            r_kc_prev    <= 16'h0000;
            r_level      <= DefaultLevel;
            r_factor     <= BaseFactor >> DefaultLevel;
            r_step_req   <= 1'b0;
            r_reseed_req <= 1'b0;
            r_cmd_valid  <= 1'b0;
            r_cmd_code   <= CmdNone;
            r_hold_cnt   <= 26'd0;
            r_hold_key   <= 8'h00;
            r_rep_phase  <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_kc_q       <= keycode;
            r_kc_prev    <= r_kc_q;
            r_level      <= w_level_nxt;
            r_factor     <= BaseFactor >> r_level;
            r_step_req   <= w_step_nxt;
            r_reseed_req <= w_reseed_nxt;
            r_cmd_valid  <= w_valid_nxt;
            r_cmd_code   <= w_code_nxt;
            r_hold_cnt   <= w_hold_cnt_nxt;
            r_hold_key   <= w_hold_key_nxt;
            r_rep_phase  <= w_rep_phase_nxt;
        end
    end

    assign RUN             = (r_state != StPaused);
    assign step_req        = r_step_req;
    assign reseed_req      = r_reseed_req;
    assign speed_level     = r_level;
    assign slowdown_factor = r_factor;
    assign cmd_valid       = r_cmd_valid;
    assign cmd_code        = r_cmd_code;

endmodule

// File: tb/tb_keycode_commander.sv
// Table-driven bench for keycode_commander: each row drives one cycle of inputs and
// holds the outputs expected right after that cycle's clock edge.
module tb_keycode_commander;

    localparam int unsigned Base = 50000000;

    logic        Clk = 1'b0;
    logic        RESET_SIM;
    logic [15:0] keycode;
    logic        game_tick;
    logic        RUN;
    logic        step_req;
    logic        reseed_req;
    logic [2:0]  speed_level;
    logic [25:0] slowdown_factor;
    logic        cmd_valid;
    logic [2:0]  cmd_code;

    always #5 Clk = ~Clk;

    keycode_commander #(
        .REPEAT_DELAY  (20),
        .REPEAT_PERIOD (5)
    ) dut (
        .Clk             (Clk),
        .RESET_SIM       (RESET_SIM),
        .keycode         (keycode),
        .game_tick       (game_tick),
        .RUN             (RUN),
        .step_req        (step_req),
        .reseed_req      (reseed_req),
        .speed_level     (speed_level),
        .slowdown_factor (slowdown_factor),
        .cmd_valid       (cmd_valid),
        .cmd_code        (cmd_code)
    );

    typedef struct {
        logic        rst;
        logic [15:0] kc;
        logic        tick;
        logic        run;
        logic        valid;
        logic [2:0]  code;
        logic [2:0]  level;
        logic        step;
        logic        reseed;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    task automatic add(input logic rst, input logic [15:0] kc, input logic tick,
                       input logic run, input logic valid, input logic [2:0] code,
                       input logic [2:0] level, input logic step, input logic reseed);
        vec_t v;
        v.rst = rst; v.kc = kc; v.tick = tick; v.run = run; v.valid = valid;
        v.code = code; v.level = level; v.step = step; v.reseed = reseed;
        vecs.push_back(v);
    endtask

    initial begin
        vec_t        v;
        vec_t        e;
        logic [9:0]  got;
        logic [9:0]  want;
        logic [25:0] want_f;
        logic [2:0]  prev_lvl;
        logic [2:0]  lvl;

        RESET_SIM = 1'b1;
        keycode   = 16'h0000;
        game_tick = 1'b0;

        // Reset state
        add(1, 16'h0000, 0, 0, 0, 0, 0, 0, 0);
        add(1, 16'h0000, 0, 0, 0, 0, 0, 0, 0);
        // Space toggles to RUNNING two edges after the change; release keeps running
        add(0, 16'h002C, 0, 0, 0, 0, 0, 0, 0);
        add(0, 16'h002C, 0, 1, 1, 1, 0, 0, 0);
        add(0, 16'h002C, 0, 1, 0, 0, 0, 0, 0);
        add(0, 16'h0000, 0, 1, 0, 0, 0, 0, 0);
        add(0, 16'h0000, 0, 1, 0, 0, 0, 0, 0);
        // Reseed ignored while running, accepted after pausing
        add(0, 16'h0015, 0, 1, 0, 0, 0, 0, 0);
        add(0, 16'h0000, 0, 1, 0, 0, 0, 0, 0);
        add(0, 16'h0000, 0, 1, 0, 0, 0, 0, 0);
        add(0, 16'h002C, 0, 1, 0, 0, 0, 0, 0);
        add(0, 16'h0000, 0, 0, 1, 1, 0, 0, 0);
        add(0, 16'h0015, 0, 0, 0, 0, 0, 0, 0);
        add(0, 16'h0000, 0, 0, 1, 5, 0, 0, 1);
        add(0, 16'h0000, 0, 0, 0, 0, 0, 0, 0);
        // Single step, ended by game_tick
        add(0, 16'h0016, 0, 0, 0, 0, 0, 0, 0);
        add(0, 16'h0000, 0, 1, 1, 2, 0, 1, 0);
        for (int i = 0; i < 8; i++) add(0, 16'h0000, 0, 1, 0, 0, 0, 0, 0);
        add(0, 16'h0000, 1, 0, 0, 0, 0, 0, 0);
        add(0, 16'h0000, 0, 0, 0, 0, 0, 0, 0);
        // Eight FASTER presses: level 1..7 then saturates, still pulsing code 3
        lvl = 3'd0;
        for (int k = 1; k <= 8; k++) begin
            add(0, 16'h002E, 0, 0, 0, 0, lvl, 0, 0);
            if (lvl != 3'd7) lvl = lvl + 3'd1;
            add(0, 16'h0000, 0, 0, 1, 3, lvl, 0, 0);
        end
        add(0, 16'h0000, 0, 0, 0, 0, 7, 0, 0);
        // Both slots new: slot A (FASTER) wins, Space dropped; later Space toggles
        add(0, 16'h2C2E, 0, 0, 0, 0, 7, 0, 0);
        add(0, 16'h0000, 0, 0, 1, 3, 7, 0, 0);
        add(0, 16'h0000, 0, 0, 0, 0, 7, 0, 0);
        add(0, 16'h002C, 0, 0, 0, 0, 7, 0, 0);
        add(0, 16'h0000, 0, 1, 1, 1, 7, 0, 0);
        add(0, 16'h002C, 0, 1, 0, 0, 7, 0, 0);
        add(0, 16'h0000, 0, 0, 1, 1, 7, 0, 0);
        add(0, 16'h0000, 0, 0, 0, 0, 7, 0, 0);
        // Hold SLOWER for 40 cycles: press then repeats at hold counts 20/25/30/35
        for (int k = 0; k < 40; k++) begin
            if (k == 1 || k == 22 || k == 27 || k == 32 || k == 37) begin
                lvl = lvl - 3'd1;
                add(0, 16'h002D, 0, 0, 1, 4, lvl, 0, 0);
            end else begin
                add(0, 16'h002D, 0, 0, 0, 0, lvl, 0, 0);
            end
        end
        add(0, 16'h0000, 0, 0, 0, 0, 2, 0, 0);
        add(0, 16'h0000, 0, 0, 0, 0, 2, 0, 0);
        // Reset mid-STEPPING, then a key held across reset
        add(0, 16'h0016, 0, 0, 0, 0, 2, 0, 0);
        add(0, 16'h0000, 0, 1, 1, 2, 2, 1, 0);
        add(1, 16'h0000, 0, 0, 0, 0, 0, 0, 0);
        add(1, 16'h002C, 0, 0, 0, 0, 0, 0, 0);
        add(0, 16'h002C, 0, 0, 0, 0, 0, 0, 0);
        add(0, 16'h002C, 0, 1, 1, 1, 0, 0, 0);
        add(0, 16'h0000, 0, 1, 0, 0, 0, 0, 0);

        prev_lvl = 3'd0;
        for (int i = 0; i < vecs.size(); i++) begin
            v         = vecs[i];
            RESET_SIM = v.rst;
            keycode   = v.kc;
            game_tick = v.tick;
            sb.push_back(v);
            @(posedge Clk);
            #1;
            e    = sb.pop_front();
            got  = {RUN, cmd_valid, cmd_code, speed_level, step_req, reseed_req};
            want = {e.run, e.valid, e.code, e.level, e.step, e.reseed};
            n_vec++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL vec%0d outputs {run,valid,code,level,step,reseed}: got %b want %b",
                         i, got, want);
            end
            want_f = e.rst ? 26'(Base) : 26'(Base >> prev_lvl);
            n_vec++;
            if (slowdown_factor !== want_f) begin
                n_fail++;
                $display("FAIL vec%0d slowdown_factor: got %0d want %0d",
                         i, slowdown_factor, want_f);
            end
            prev_lvl = e.level;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
